clock_mode_ctrl: RTL



---
 rtl/clock_ctrl_pkg.sv | 40 ++++
 rtl/btn_edge.sv | 19 +
 rtl/clock_mode_ctrl.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/clock_ctrl_pkg.sv
// Shared types and timing constants for the alarm-clock mode/alarm controller.
package clock_ctrl_pkg;

  typedef enum logic [2:0] {
    MODE_RUN       = 3'd0,
    MODE_SET_T_MIN = 3'd1,
    MODE_SET_T_HR  = 3'd2,
    MODE_SET_A_MIN = 3'd3,
    MODE_SET_A_HR  = 3'd4
  } mode_t;

  typedef enum logic [1:0] {
    ALM_IDLE   = 2'd0,
    ALM_RING   = 2'd1,
    ALM_SNOOZE = 2'd2
  } alm_state_t;

  localparam int SNOOZE_SEC = 300;
  localparam int RING_SEC   = 60;
  localparam int REPEAT_DLY = 2;

  function automatic mode_t next_mode(input mode_t m);
    case (m)
      MODE_RUN:       return MODE_SET_T_MIN;
      MODE_SET_T_MIN: return MODE_SET_T_HR;
      MODE_SET_T_HR:  return MODE_SET_A_MIN;
      MODE_SET_A_MIN: return MODE_SET_A_HR;
      default:        return MODE_RUN;
    endcase
  endfunction

  function automatic logic [1:0] blink_of(input mode_t m);
    case (m)
      MODE_SET_T_MIN, MODE_SET_A_MIN: return 2'b01;
      MODE_SET_T_HR,  MODE_SET_A_HR:  return 2'b10;
      default:                        return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/btn_edge.sv
// Rising-edge detector: the edge is combinational on the current sample, the
// history flag records "last sample was 0" and clears on reset so a held button gives no edge.
module btn_edge (
  input  logic clk,
  input  logic reset,
  input  logic i_btn,
  output logic o_edge
);

  logic r_was_low;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_was_low <= 1'b0;
    else       r_was_low <= ~i_btn;
  end

  assign o_edge = i_btn & r_was_low;

endmodule

// File: rtl/clock_mode_ctrl.sv
// Mode and alarm controller: button/tick decoding into registered one-cycle strobes.
// Strobes fire in the cycle after the sampled edge or tick; mode advance beats btn_adv.
module clock_mode_ctrl
  import clock_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       i_tick_1hz,
  input  logic       i_tick_2hz,
  input  logic       i_btn_mode,
  input  logic       i_btn_adv,
  input  logic       i_btn_off,
  input  logic       i_alarm_arm,
  input  logic [7:0] i_cur_sec,
  input  logic [7:0] i_cur_min,
  input  logic [7:0] i_cur_hr,
  input  logic [7:0] i_alm_min,
  input  logic [7:0] i_alm_hr,
  output logic       o_t_sec_inc,
  output logic       o_t_min_inc,
  output logic       o_t_hr_inc,
  output logic       o_a_min_inc,
  output logic       o_a_hr_inc,
  output logic       o_t_sec_clr,
  output mode_t      o_mode,
  output logic       o_disp_alarm,
  output logic [1:0] o_blink,
  output logic       o_ringing,
  output alm_state_t o_alm_state
);

  localparam logic [1:0] HOLD_DLY  = 2'(REPEAT_DLY);
  localparam logic [5:0] RING_LAST = 6'(RING_SEC - 1);
  localparam logic [8:0] SNZ_LOAD  = 9'(SNOOZE_SEC);

  logic w_mode_edge, w_adv_edge, w_off_edge;
  logic w_adv_fire, w_alm_kill, w_time_match;
  mode_t w_mode_nxt;

  mode_t      r_mode;
  alm_state_t r_alm;
  logic [1:0] r_hold;
  logic [5:0] r_ring_cnt;
  logic [8:0] r_snz_cnt;
  logic [1:0] r_blink;
  logic       r_disp, r_ringing;
  logic       r_t_sec_inc, r_t_min_inc, r_t_hr_inc, r_a_min_inc, r_a_hr_inc, r_t_sec_clr;

  btn_edge u_edge_mode (.clk(clk), .reset(reset), .i_btn(i_btn_mode), .o_edge(w_mode_edge));
  btn_edge u_edge_adv  (.clk(clk), .reset(reset), .i_btn(i_btn_adv),  .o_edge(w_adv_edge));
  btn_edge u_edge_off  (.clk(clk), .reset(reset), .i_btn(i_btn_off),  .o_edge(w_off_edge));

  assign w_mode_nxt = w_mode_edge ? next_mode(r_mode) : r_mode;
  // Auto-repeat fires only once the hold counter has already absorbed REPEAT_DLY ticks.
  assign w_adv_fire = w_adv_edge | (i_btn_adv & i_tick_2hz & (r_hold == HOLD_DLY));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mode      <= MODE_RUN;
      r_blink     <= 2'b00;
      r_disp      <= 1'b0;
      r_hold      <= 2'd0;
      r_t_sec_inc <= 1'b0;
      r_t_min_inc <= 1'b0;
      r_t_hr_inc  <= 1'b0;
      r_a_min_inc <= 1'b0;
      r_a_hr_inc  <= 1'b0;
      r_t_sec_clr <= 1'b0;
    end else begin
      r_t_sec_inc <= 1'b0;
      r_t_min_inc <= 1'b0;
      r_t_hr_inc  <= 1'b0;
      r_a_min_inc <= 1'b0;
      r_a_hr_inc  <= 1'b0;
      r_t_sec_clr <= 1'b0;
      r_mode      <= w_mode_nxt;
      r_blink     <= blink_of(w_mode_nxt);
      r_disp      <= (w_mode_nxt == MODE_SET_A_MIN) || (w_mode_nxt == MODE_SET_A_HR);
      if (w_mode_edge) begin
        r_hold      <= 2'd0;
        r_t_sec_clr <= (r_mode == MODE_RUN);
      end else if (r_mode == MODE_RUN) begin
        r_hold      <= 2'd0;
        r_t_sec_inc <= i_tick_1hz;
      end else begin
        if (!i_btn_adv)                        r_hold <= 2'd0;
        else if (i_tick_2hz && r_hold < HOLD_DLY) r_hold <= r_hold + 2'd1;
        if (w_adv_fire) begin
          case (r_mode)
            MODE_SET_T_MIN: r_t_min_inc <= 1'b1;
            MODE_SET_T_HR:  r_t_hr_inc  <= 1'b1;
            MODE_SET_A_MIN: r_a_min_inc <= 1'b1;
            MODE_SET_A_HR:  r_a_hr_inc  <= 1'b1;
            default: ;
          endcase
        end
      end
    end
  end

  // Leaving RUN (or disarming) silences the alarm before any other transition.
  assign w_alm_kill   = ~i_alarm_arm | (r_mode != MODE_RUN) | w_mode_edge;
  assign w_time_match = i_tick_1hz & (i_cur_hr == i_alm_hr) & (i_cur_min == i_alm_min) &
                        (i_cur_sec == 8'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_alm      <= ALM_IDLE;
      r_ring_cnt <= 6'd0;
      r_snz_cnt  <= 9'd0;
      r_ringing  <= 1'b0;
    end else if (w_alm_kill) begin
      r_alm      <= ALM_IDLE;
      r_ring_cnt <= 6'd0;
      r_snz_cnt  <= 9'd0;
      r_ringing  <= 1'b0;
    end else begin
      case (r_alm)
        ALM_IDLE: begin
          if (w_time_match) begin
            r_alm      <= ALM_RING;
            r_ring_cnt <= 6'd0;
            r_ringing  <= 1'b1;
          end
        end
        ALM_RING: begin
          if (w_off_edge) begin
            r_alm      <= ALM_IDLE;
            r_ring_cnt <= 6'd0;
            r_ringing  <= 1'b0;
          end else if (w_adv_edge) begin
            r_alm      <= ALM_SNOOZE;
            r_ring_cnt <= 6'd0;
            r_snz_cnt  <= SNZ_LOAD;
            r_ringing  <= 1'b0;
          end else if (i_tick_1hz) begin
            if (r_ring_cnt == RING_LAST) begin
              r_alm      <= ALM_IDLE;
              r_ring_cnt <= 6'd0;
              r_ringing  <= 1'b0;
            end else begin
              r_ring_cnt <= r_ring_cnt + 6'd1;
            end
          end
        end
        ALM_SNOOZE: begin
          if (w_off_edge) begin
            r_alm     <= ALM_IDLE;
            r_snz_cnt <= 9'd0;
          end else if (i_tick_1hz) begin
            if (r_snz_cnt == 9'd1) begin
              r_alm      <= ALM_RING;
              r_snz_cnt  <= 9'd0;
              r_ring_cnt <= 6'd0;
              r_ringing  <= 1'b1;
            end else begin
              r_snz_cnt <= r_snz_cnt - 9'd1;
            end
          end
        end
        default: begin
          r_alm     <= ALM_IDLE;
          r_ringing <= 1'b0;
        end
      endcase
    end
  end

  assign o_t_sec_inc  = r_t_sec_inc;
  assign o_t_min_inc  = r_t_min_inc;
  assign o_t_hr_inc   = r_t_hr_inc;
  assign o_a_min_inc  = r_a_min_inc;
  assign o_a_hr_inc   = r_a_hr_inc;
  assign o_t_sec_clr  = r_t_sec_clr;
  assign o_mode       = r_mode;
  assign o_disp_alarm = r_disp;
  assign o_blink      = r_blink;
  assign o_ringing    = r_ringing;
  assign o_alm_state  = r_alm;

endmodule
